// File: rtl/ifu_pkg.sv
// Shared types and helpers for the IFU fetch buffer.
package ifu_pkg;

    localparam int FB_HW = 8;

    // One 16-byte fetch packet: data, packet base address [31:4] and the set of
    // halfwords that are still waiting to be handed to decode.
    typedef struct packed {
        logic [127:0]     data;
        logic [27:0]      base;
        logic [FB_HW-1:0] mask;
    } fb_entry_t;

    // RISC-V compressed encodings are every opcode whose low two bits are not 2'b11.
    function automatic logic is_compressed(input logic [15:0] hw);
        return hw[1:0] != 2'b11;
    endfunction

    // Lowest pending halfword. Masks are always a contiguous run ending at bit 7,
    // so this is also the current read offset within the packet.
    function automatic logic [2:0] first_hw(input logic [FB_HW-1:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = FB_HW - 1; i >= 0; i--) begin
            if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic logic [15:0] get_hw(input logic [127:0] d, input logic [2:0] idx);
        return d[{idx, 4'b0000} +: 16];
    endfunction

endpackage

// File: rtl/ifu_fb_extract.sv
// Combinational instruction extraction from the head packet (and the
// following packet when a 32-bit instruction straddles the boundary).
module ifu_fb_extract
    import ifu_pkg::*;
(
    input  fb_entry_t        head,
    input  logic [127:0]     next_data,
    input  logic [FB_HW-1:0] next_mask,
    output logic             valid,
    output logic [31:0]      instr,
    output logic [30:0]      pc,
    output logic             is_16,
    output logic             span,
    output logic [FB_HW-1:0] head_clr,
    output logic [FB_HW-1:0] next_clr
);

    logic [2:0]  off;
    logic [2:0]  off1;
    logic [2:0]  noff;
    logic [15:0] lo;
    logic [15:0] hi;

    // Pick the low halfword at the read offset, then its partner either from the
    // same packet or from the first pending halfword of the next packet.
    always_comb begin
        off      = first_hw(head.mask);
        off1     = off + 3'd1;
        noff     = first_hw(next_mask);
        lo       = get_hw(head.data, off);
        hi       = 16'h0000;
        is_16    = is_compressed(lo);
        valid    = 1'b0;
        span     = 1'b0;
        head_clr = '0;
        next_clr = '0;
        if (|head.mask) begin
            if (is_16) begin
                valid    = 1'b1;
                head_clr = FB_HW'(1) << off;
            end else if (off != 3'd7) begin
                hi       = get_hw(head.data, off1);
                valid    = head.mask[off1];
                head_clr = FB_HW'(3) << off;
            end else begin
                hi       = get_hw(next_data, noff);
                valid    = |next_mask;
                span     = 1'b1;
                head_clr = FB_HW'(8'h80);
                next_clr = FB_HW'(1) << noff;
            end
        end
        instr = is_16 ? {16'h0000, lo} : {hi, lo};
        pc    = {head.base, off};
    end

endmodule

// File: rtl/ifu_fetch_buf.sv
// IFU fetch buffer: accepts 16-byte F2 fetch packets and hands single 16/32-bit
// instructions to decode, reporting entries freed back to fetch control.
// Optional build macro: RV_FB_BYPASS_EN (present straight from the write port
// when the buffer is empty).
module ifu_fetch_buf
    import ifu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int HW    = 8
) (
    input  logic         clk,
    input  logic         rst_l,
    input  logic         fb_wr_valid_f2,
    input  logic [30:0]  fb_wr_addr_f2,
    input  logic [127:0] fb_wr_data_f2,
    input  logic         exu_flush_final,
    input  logic         dec_ib_ready,
    output logic         ib_valid,
    output logic [31:0]  ib_instr,
    output logic [30:0]  ib_pc,
    output logic         ib_is_16,
    output logic         ifu_fb_consume1,
    output logic         ifu_fb_consume2,
    output logic         fb_overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [127:0]  data_q [DEPTH];
    logic [27:0]   base_q [DEPTH];
    logic [HW-1:0] mask_q [DEPTH];
    logic [PW-1:0] wrptr;
    logic [PW-1:0] rdptr;
    logic [PW-1:0] rdptr_p1;
    logic [CW-1:0] count;

    fb_entry_t        wr_ent;
    fb_entry_t        ex_head;
    logic [127:0]     ex_next_data;
    logic [FB_HW-1:0] ex_next_mask;
    logic [HW-1:0]    wr_mask_full;

    logic             ex_valid;
    logic             span;
    logic [FB_HW-1:0] head_clr;
    logic [FB_HW-1:0] next_clr;
    logic [FB_HW-1:0] head_mask_n;
    logic [FB_HW-1:0] next_mask_n;

    logic       bypass;
    logic       have_data;
    logic       fire;
    logic       head_free;
    logic       next_free;
    logic [1:0] freed;
    logic       wr_en;
    logic       full;
    logic       bypass_drop;
    logic       wr_accept;
    logic       overflow_set;
    logic [FB_HW-1:0] wr_mask;

    assign rdptr_p1     = rdptr + PW'(1);
    assign wr_mask_full = {HW{1'b1}} << fb_wr_addr_f2[2:0];

`ifdef RV_FB_BYPASS_EN
    assign bypass = (count == '0) & fb_wr_valid_f2 & ~exu_flush_final;
`else
    assign bypass = 1'b0;
`endif

    // Extraction source: the incoming packet when bypassing, otherwise the head
    // entry and the one behind it.
    always_comb begin
        wr_ent.data = fb_wr_data_f2;
        wr_ent.base = fb_wr_addr_f2[30:3];
        wr_ent.mask = wr_mask_full;
        if (bypass) begin
            ex_head      = wr_ent;
            ex_next_data = '0;
            ex_next_mask = '0;
        end else begin
            ex_head.data = data_q[rdptr];
            ex_head.base = base_q[rdptr];
            ex_head.mask = mask_q[rdptr];
            ex_next_data = data_q[rdptr_p1];
            ex_next_mask = mask_q[rdptr_p1];
        end
    end

    ifu_fb_extract u_extract (
        .head      (ex_head),
        .next_data (ex_next_data),
        .next_mask (ex_next_mask),
        .valid     (ex_valid),
        .instr     (ib_instr),
        .pc        (ib_pc),
        .is_16     (ib_is_16),
        .span      (span),
        .head_clr  (head_clr),
        .next_clr  (next_clr)
    );

    assign have_data = (count != '0) | bypass;
    assign ib_valid  = ex_valid & have_data & ~exu_flush_final;
    assign fire      = ib_valid & dec_ib_ready;

    assign head_mask_n = ex_head.mask & ~(fire ? head_clr : '0);
    assign next_mask_n = ex_next_mask & ~(fire ? next_clr : '0);

    // A bypassed packet was never in the buffer, so consuming from it frees nothing.
    assign head_free = fire & ~bypass & (head_mask_n == '0);
    assign next_free = fire & span & (next_mask_n == '0);
    assign freed     = {1'b0, head_free} + {1'b0, next_free};

    assign ifu_fb_consume1 = (freed == 2'd1);
    assign ifu_fb_consume2 = (freed == 2'd2);

    assign wr_en        = fb_wr_valid_f2 & ~exu_flush_final;
    assign full         = (count == CW'(DEPTH));
    assign bypass_drop  = bypass & (head_mask_n == '0);
    assign wr_accept    = wr_en & ~bypass_drop & (~full | (freed != 2'd0));
    assign overflow_set = wr_en & full & (freed == 2'd0);
    assign wr_mask      = bypass ? head_mask_n : wr_ent.mask;

    // Halfword-valid masks: clear consumed halfwords, then load a new packet;
    // the load wins when a full buffer recycles the entry just freed.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < DEPTH; i++) mask_q[i] <= '0;
        end else if (exu_flush_final) begin
            for (int i = 0; i < DEPTH; i++) mask_q[i] <= '0;
        end else begin
            if (fire && !bypass) begin
                mask_q[rdptr] <= head_mask_n;
                if (span) mask_q[rdptr_p1] <= next_mask_n;
            end
            if (wr_accept) mask_q[wrptr] <= wr_mask;
        end
    end

    // Packet payload and base address; qualified by the mask, so no reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            data_q[wrptr] <= fb_wr_data_f2;
            base_q[wrptr] <= fb_wr_addr_f2[30:3];
        end
    end

    // Pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wrptr       <= '0;
            rdptr       <= '0;
            count       <= '0;
            fb_overflow <= 1'b0;
        end else begin
            if (overflow_set) fb_overflow <= 1'b1;
            if (exu_flush_final) begin
                wrptr <= '0;
                rdptr <= '0;
                count <= '0;
            end else begin
                wrptr <= wrptr + PW'(wr_accept);
                rdptr <= rdptr + PW'(freed);
                count <= count + CW'(wr_accept) - CW'(freed);
            end
        end
    end

endmodule

// File: tb/tb_ifu_fetch_buf.sv
// Scoreboard bench for ifu_fetch_buf: expected instructions are queued as
// packets are driven and compared whenever decode accepts one.
module tb_ifu_fetch_buf;

`ifdef RV_FB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_l;
    logic         fb_wr_valid_f2;
    logic [30:0]  fb_wr_addr_f2;
    logic [127:0] fb_wr_data_f2;
    logic         exu_flush_final;
    logic         dec_ib_ready;
    logic         ib_valid;
    logic [31:0]  ib_instr;
    logic [30:0]  ib_pc;
    logic         ib_is_16;
    logic         ifu_fb_consume1;
    logic         ifu_fb_consume2;
    logic         fb_overflow;

    always #5 clk = ~clk;

    ifu_fetch_buf #(.DEPTH(4), .HW(8)) dut (
        .clk             (clk),
        .rst_l           (rst_l),
        .fb_wr_valid_f2  (fb_wr_valid_f2),
        .fb_wr_addr_f2   (fb_wr_addr_f2),
        .fb_wr_data_f2   (fb_wr_data_f2),
        .exu_flush_final (exu_flush_final),
        .dec_ib_ready    (dec_ib_ready),
        .ib_valid        (ib_valid),
        .ib_instr        (ib_instr),
        .ib_pc           (ib_pc),
        .ib_is_16        (ib_is_16),
        .ifu_fb_consume1 (ifu_fb_consume1),
        .ifu_fb_consume2 (ifu_fb_consume2),
        .fb_overflow     (fb_overflow)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [30:0] pc;
        logic        is16;
    } exp_t;

    exp_t        sb [$];
    exp_t        mon_e;
    logic [30:0] c1_pcs [$];
    logic [30:0] c2_pcs [$];
    int          n_chk  = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    function automatic logic [127:0] pkt_fill(input logic [15:0] b);
        logic [127:0] d;
        for (int i = 0; i < 8; i++) d[16*i +: 16] = b + 16'(i * 16);
        return d;
    endfunction

    task automatic push_c(input logic [31:0] pc_b, input logic [15:0] hw);
        exp_t e;
        e.instr = {16'h0000, hw};
        e.pc    = pc_b[31:1];
        e.is16  = 1'b1;
        sb.push_back(e);
    endtask

    task automatic push_w(input logic [31:0] pc_b, input logic [15:0] lo, input logic [15:0] hi);
        exp_t e;
        e.instr = {hi, lo};
        e.pc    = pc_b[31:1];
        e.is16  = 1'b0;
        sb.push_back(e);
    endtask

    task automatic push_pkt(input logic [31:0] a, input logic [15:0] b);
        for (int i = 0; i < 8; i++) push_c(a + 32'(2 * i), b + 16'(i * 16));
    endtask

    // Drive one cycle's inputs and stop at the falling edge for mid-cycle checks.
    task automatic cyc_mid(input logic v, input logic [31:0] a, input logic [127:0] d, input logic fl);
        fb_wr_valid_f2  = v;
        fb_wr_addr_f2   = a[31:1];
        fb_wr_data_f2   = d;
        exu_flush_final = fl;
        @(negedge clk);
    endtask

    task automatic end_cyc();
        @(posedge clk);
        #1;
        fb_wr_valid_f2  = 1'b0;
        exu_flush_final = 1'b0;
    endtask

    task automatic cyc(input logic v, input logic [31:0] a, input logic [127:0] d, input logic fl);
        cyc_mid(v, a, d, fl);
        end_cyc();
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain"}, 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic clr_consume();
        c1_pcs.delete();
        c2_pcs.delete();
    endtask

    // Monitor: compare every accepted instruction, record consume pulses.
    always @(negedge clk) begin
        if (rst_l) begin
            if (ib_valid && dec_ib_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_instr", {32'h0, ib_instr}, 64'h0);
                end else begin
                    mon_e = sb.pop_front();
                    check("instr", 64'(ib_instr), 64'(mon_e.instr));
                    check("pc",    64'(ib_pc),    64'(mon_e.pc));
                    check("is16",  64'(ib_is_16), 64'(mon_e.is16));
                end
            end
            if (ifu_fb_consume1 || ifu_fb_consume2)
                check("consume_excl", 64'(ifu_fb_consume1 & ifu_fb_consume2), 64'd0);
            if (ifu_fb_consume1) c1_pcs.push_back(ib_pc);
            if (ifu_fb_consume2) c2_pcs.push_back(ib_pc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [127:0] d;

        rst_l           = 1'b0;
        fb_wr_valid_f2  = 1'b0;
        fb_wr_addr_f2   = '0;
        fb_wr_data_f2   = '0;
        exu_flush_final = 1'b0;
        dec_ib_ready    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid",    64'(ib_valid),        64'd0);
        check("rst_consume1", 64'(ifu_fb_consume1), 64'd0);
        check("rst_consume2", 64'(ifu_fb_consume2), 64'd0);
        check("rst_overflow", 64'(fb_overflow),     64'd0);
        @(posedge clk);
        #1;
        rst_l = 1'b1;
        @(posedge clk);
        #1;

        // Eight compressed instructions from one packet.
        clr_consume();
        dec_ib_ready = 1'b1;
        for (int i = 0; i < 8; i++) push_c(32'h1000 + 32'(2 * i), 16'h0001);
        cyc_mid(1'b1, 32'h1000, {8{16'h0001}}, 1'b0);
        check("t1_latency", 64'(ib_valid), 64'(BYP));
        end_cyc();
        drain("t1");
        @(negedge clk);
        check("t1_idle",   64'(ib_valid),      64'd0);
        check("t1_c1_num", 64'(c1_pcs.size()), 64'd1);
        check("t1_c1_pc",  64'((c1_pcs.size() > 0) ? c1_pcs[0] : 31'h7fffffff), 64'(32'h100E >> 1));
        check("t1_c2_num", 64'(c2_pcs.size()), 64'd0);
        @(posedge clk);
        #1;

        // 32-bit instruction split across two packets; second packet stays live.
        clr_consume();
        dec_ib_ready = 1'b0;
        push_w(32'h100E, 16'h0003, 16'h1234);
        for (int i = 1; i < 8; i++) push_c(32'h1010 + 32'(2 * i), 16'h0101 + 16'(i * 16));
        d = '0;
        d[127:112] = 16'h0003;
        cyc(1'b1, 32'h100E, d, 1'b0);
        d = pkt_fill(16'h0101);
        d[15:0] = 16'h1234;
        cyc(1'b1, 32'h1010, d, 1'b0);
        @(negedge clk);
        check("t2_span_ready", 64'(ib_valid), 64'd1);
        @(posedge clk);
        #1;
        dec_ib_ready = 1'b1;
        drain("t2");
        check("t2_c1_num", 64'(c1_pcs.size()), 64'd2);
        check("t2_c1_pc0", 64'((c1_pcs.size() > 0) ? c1_pcs[0] : 31'h7fffffff), 64'(32'h100E >> 1));
        check("t2_c1_pc1", 64'((c1_pcs.size() > 1) ? c1_pcs[1] : 31'h7fffffff), 64'(32'h101E >> 1));
        check("t2_c2_num", 64'(c2_pcs.size()), 64'd0);

        // Spanning instruction that empties both packets.
        clr_consume();
        d = '0;
        d[127:112] = 16'h0003;
        cyc(1'b1, 32'h100E, d, 1'b0);
        @(negedge clk);
        check("t3_missing_hi", 64'(ib_valid), 64'd0);
        @(posedge clk);
        #1;
        push_w(32'h100E, 16'h0003, 16'hABCD);
        d = '0;
        d[127:112] = 16'hABCD;
        cyc(1'b1, 32'h101E, d, 1'b0);
        drain("t3");
        check("t3_c2_num", 64'(c2_pcs.size()), 64'd1);
        check("t3_c2_pc",  64'((c2_pcs.size() > 0) ? c2_pcs[0] : 31'h7fffffff), 64'(32'h100E >> 1));
        check("t3_c1_num", 64'(c1_pcs.size()), 64'd0);

        // Full buffer with a write while the head frees: accepted.
        dec_ib_ready = 1'b0;
        push_c(32'h300E, 16'h0271);
        cyc(1'b1, 32'h300E, pkt_fill(16'h0201), 1'b0);
        push_pkt(32'h3010, 16'h0301);
        cyc(1'b1, 32'h3010, pkt_fill(16'h0301), 1'b0);
        push_pkt(32'h3020, 16'h0401);
        cyc(1'b1, 32'h3020, pkt_fill(16'h0401), 1'b0);
        push_pkt(32'h3030, 16'h0501);
        cyc(1'b1, 32'h3030, pkt_fill(16'h0501), 1'b0);
        push_pkt(32'h3040, 16'h0601);
        dec_ib_ready = 1'b1;
        cyc_mid(1'b1, 32'h3040, pkt_fill(16'h0601), 1'b0);
        check("t4a_consume1", 64'(ifu_fb_consume1), 64'd1);
        end_cyc();
        @(negedge clk);
        check("t4a_no_overflow", 64'(fb_overflow), 64'd0);
        @(posedge clk);
        #1;
        drain("t4a");

        // Full buffer with no entry freed: write dropped, overflow sticks.
        dec_ib_ready = 1'b0;
        for (int p = 0; p < 4; p++) begin
            push_pkt(32'h4000 + 32'(16 * p), 16'h0701 + 16'(p * 256));
            cyc(1'b1, 32'h4000 + 32'(16 * p), pkt_fill(16'h0701 + 16'(p * 256)), 1'b0);
        end
        cyc_mid(1'b1, 32'h4040, pkt_fill(16'h0B01), 1'b0);
        check("t4b_overflow_pre", 64'(fb_overflow), 64'd0);
        end_cyc();
        @(negedge clk);
        check("t4b_overflow", 64'(fb_overflow), 64'd1);
        @(posedge clk);
        #1;
        dec_ib_ready = 1'b1;
        drain("t4b");
        @(negedge clk);
        check("t4b_idle", 64'(ib_valid), 64'd0);
        @(posedge clk);
        #1;

        // Flush with three live entries and a concurrent write.
        clr_consume();
        dec_ib_ready = 1'b0;
        for (int p = 0; p < 3; p++)
            cyc(1'b1, 32'h5000 + 32'(16 * p), pkt_fill(16'h0C01), 1'b0);
        dec_ib_ready = 1'b1;
        cyc_mid(1'b1, 32'h5030, pkt_fill(16'h0D01), 1'b1);
        check("t5_flush_valid",    64'(ib_valid),        64'd0);
        check("t5_flush_consume1", 64'(ifu_fb_consume1), 64'd0);
        check("t5_flush_consume2", 64'(ifu_fb_consume2), 64'd0);
        end_cyc();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_empty", 64'(ib_valid), 64'd0);
            @(posedge clk);
            #1;
        end
        check("t5_overflow_kept", 64'(fb_overflow), 64'd1);
        check("t5_no_consume", 64'(c1_pcs.size() + c2_pcs.size()), 64'd0);

        // Mixed 16/32-bit packet after the flush.
        clr_consume();
        d = {16'h0041, 16'h0031, 16'hCAFE, 16'h0007, 16'h0021, 16'hBEEF, 16'h0003, 16'h0011};
        push_c(32'h6000, 16'h0011);
        push_w(32'h6002, 16'h0003, 16'hBEEF);
        push_c(32'h6006, 16'h0021);
        push_w(32'h6008, 16'h0007, 16'hCAFE);
        push_c(32'h600C, 16'h0031);
        push_c(32'h600E, 16'h0041);
        cyc(1'b1, 32'h6000, d, 1'b0);
        drain("t6");
        check("t6_c1_num", 64'(c1_pcs.size()), 64'd1);
        check("t6_c1_pc",  64'((c1_pcs.size() > 0) ? c1_pcs[0] : 31'h7fffffff), 64'(32'h600E >> 1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
